// File: rtl/drum_motor_driver_if.sv
// Command, feedback and drive signals between the washer controller and the drum motor stage.
interface drum_motor_driver_if;
   localparam int unsigned SPEED_W = 10;

   logic               motor_en;
   logic               spin_mode;
   logic [SPEED_W-1:0] target_speed;
   logic [SPEED_W-1:0] speed_fb;
   logic               vibration;
   logic               pwm_out;
   logic               dir;
   logic               brake;
   logic               at_speed;
   logic               fault;

   modport master (
      output motor_en, spin_mode, target_speed, speed_fb, vibration,
      input  pwm_out, dir, brake, at_speed, fault
   );

   modport slave (
      input  motor_en, spin_mode, target_speed, speed_fb, vibration,
      output pwm_out, dir, brake, at_speed, fault
   );
endinterface

// File: rtl/drum_motor_driver.sv
// Drum motor drive stage: soft start/stop duty ramp, wash agitation reversal,
// stall and vibration fault handling, PWM generation.
module drum_motor_driver #(
   parameter int unsigned RAMP_DIV     = 100,
   parameter int unsigned REV_PERIOD   = 1000,
   parameter int unsigned DWELL_CYCLES = 50,
   parameter int unsigned STALL_CYCLES = 200
) (
   input  logic               clk,
   input  logic               reset_n,
   drum_motor_driver_if.slave bus
);

   localparam int unsigned DUTY_W  = 8;
   localparam int unsigned SPEED_W = 10;
   localparam int unsigned PRE_W   = (RAMP_DIV > 1)     ? $clog2(RAMP_DIV)     : 1;
   localparam int unsigned REV_W   = (REV_PERIOD > 1)   ? $clog2(REV_PERIOD)   : 1;
   localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int unsigned STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, RUN, DECEL, DWELL, FAULT} state_t;

   state_t             state_q, state_d;
   logic [DUTY_W-1:0]  duty_q, duty_d, duty_ramp_c, duty_tgt_c;
   logic               dir_q, dir_d;
   logic               rev_pend_q, rev_pend_d;
   logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [PRE_W-1:0]   pre_cnt_q;
   logic [DUTY_W-1:0]  pwm_cnt_q;
   logic               pwm_q, brake_q, at_speed_q, fault_q;
   logic               tick_c, stall_cond_c, stall_hit_c, rev_hit_c;

   assign duty_tgt_c   = bus.target_speed[SPEED_W-1:2];
   assign tick_c       = (pre_cnt_q == PRE_W'(RAMP_DIV - 1));
   assign stall_cond_c = (state_q == RUN) && (duty_q == duty_tgt_c) && (duty_q != '0) &&
                         (bus.speed_fb < (bus.target_speed >> 2));
   assign stall_hit_c  = stall_cond_c && (stall_cnt_q == STALL_W'(STALL_CYCLES - 1));
   assign rev_hit_c    = !bus.spin_mode && (rev_cnt_q == REV_W'(REV_PERIOD - 1));

   // One-LSB duty step toward the target on each ramp tick
   always_comb begin
      duty_ramp_c = duty_q;
      if (tick_c) begin
         if (duty_q < duty_tgt_c)      duty_ramp_c = duty_q + DUTY_W'(1);
         else if (duty_q > duty_tgt_c) duty_ramp_c = duty_q - DUTY_W'(1);
      end
   end

   // Next-state, duty, direction and counter logic
   always_comb begin
      state_d     = state_q;
      duty_d      = duty_q;
      dir_d       = dir_q;
      rev_pend_d  = rev_pend_q;
      rev_cnt_d   = '0;
      dwell_cnt_d = '0;
      stall_cnt_d = '0;
      unique case (state_q)
         IDLE: begin
            duty_d = '0;
            if (bus.motor_en) begin
               state_d = RUN;
               dir_d   = 1'b1;
            end
         end
         RUN: begin
            duty_d      = duty_ramp_c;
            rev_cnt_d   = bus.spin_mode ? rev_cnt_q : rev_cnt_q + REV_W'(1);
            stall_cnt_d = stall_cond_c ? stall_cnt_q + STALL_W'(1) : '0;
            if (!bus.motor_en) begin
               state_d    = DECEL;
               rev_pend_d = 1'b0;
            end else if (rev_hit_c) begin
               state_d    = DECEL;
               rev_pend_d = 1'b1;
            end else if (stall_hit_c) begin
               state_d = FAULT;
               duty_d  = '0;
            end
         end
         DECEL: begin
            if (bus.motor_en && !rev_pend_q) state_d = RUN;
            else if (duty_q == '0)           state_d = rev_pend_q ? DWELL : IDLE;
            else if (tick_c)                 duty_d  = duty_q - DUTY_W'(1);
         end
         DWELL: begin
            duty_d = '0;
            if (dwell_cnt_q == DWELL_W'(DWELL_CYCLES - 1)) begin
               dir_d      = !dir_q;
               rev_pend_d = 1'b0;
               state_d    = bus.motor_en ? RUN : IDLE;
            end else begin
               dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
            end
         end
         FAULT: begin
            duty_d = '0;
            if (!bus.vibration && !bus.motor_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Vibration overrides every other transition and kills drive at once
      if (bus.vibration) begin
         state_d     = FAULT;
         duty_d      = '0;
         rev_pend_d  = 1'b0;
         rev_cnt_d   = '0;
         dwell_cnt_d = '0;
         stall_cnt_d = '0;
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         duty_q      <= '0;
         dir_q       <= 1'b1;
         rev_pend_q  <= 1'b0;
         rev_cnt_q   <= '0;
         dwell_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         dir_q       <= dir_d;
         rev_pend_q  <= rev_pend_d;
         rev_cnt_q   <= rev_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Free-running ramp prescaler and PWM carrier counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt_q <= '0;
         pwm_cnt_q <= '0;
      end else begin
         pre_cnt_q <= tick_c ? '0 : pre_cnt_q + PRE_W'(1);
         pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
      end
   end

   // Registered outputs; brake/fault follow the state being entered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_q      <= 1'b0;
         brake_q    <= 1'b0;
         at_speed_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         pwm_q      <= (pwm_cnt_q < duty_q);
         brake_q    <= (state_d == DWELL) || (state_d == FAULT);
         at_speed_q <= (state_q == RUN) && (duty_q == duty_tgt_c) && (duty_q != '0);
         fault_q    <= (state_d == FAULT);
      end
   end

   assign bus.pwm_out  = pwm_q;
   assign bus.dir      = dir_q;
   assign bus.brake    = brake_q;
   assign bus.at_speed = at_speed_q;
   assign bus.fault    = fault_q;

endmodule

// File: tb/tb_drum_motor_driver.sv
// Directed bench for drum_motor_driver with an expected-value queue.
module tb_drum_motor_driver;
   localparam int unsigned RAMP_DIV     = 4;
   localparam int unsigned REV_PERIOD   = 64;
   localparam int unsigned DWELL_CYCLES = 8;
   localparam int unsigned STALL_CYCLES = 16;

   localparam int SEL_PWM   = 0;
   localparam int SEL_DIR   = 1;
   localparam int SEL_BRAKE = 2;
   localparam int SEL_AT    = 3;
   localparam int SEL_FAULT = 4;

   typedef struct {
      string tag;
      int    lo;
      int    hi;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n;
   int   bad;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   drum_motor_driver_if bus ();

   drum_motor_driver #(
      .RAMP_DIV    (RAMP_DIV),
      .REV_PERIOD  (REV_PERIOD),
      .DWELL_CYCLES(DWELL_CYCLES),
      .STALL_CYCLES(STALL_CYCLES)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Output value as 0/1, with anything unknown mapped to 2
   function automatic int sig(input int sel);
      logic v;
      case (sel)
         SEL_PWM:   v = bus.pwm_out;
         SEL_DIR:   v = bus.dir;
         SEL_BRAKE: v = bus.brake;
         SEL_AT:    v = bus.at_speed;
         default:   v = bus.fault;
      endcase
      if (v === 1'b1) return 1;
      if (v === 1'b0) return 0;
      return 2;
   endfunction

   task automatic push_exp(input string tag, input int lo, input int hi);
      exp_t e;
      e.tag = tag;
      e.lo  = lo;
      e.hi  = hi;
      sb.push_back(e);
   endtask

   task automatic check_obs(input int obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0d with no expected entry", obs);
      end else begin
         e = sb.pop_front();
         if (e.lo == e.hi) begin
            assert (obs === e.lo) else begin
               errors++;
               $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.lo);
            end
         end else begin
            assert ((obs >= e.lo) && (obs <= e.hi)) else begin
               errors++;
               $error("FAIL %s: observed %0d expected %0d..%0d", e.tag, obs, e.lo, e.hi);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Clocks until an output takes a value; limit+1 means it never did
   task automatic wait_for(input int sel, input int val, input int limit, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while ((sig(sel) != val) && (cnt <= limit));
   endtask

   task automatic count_high(input int sel, input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         step();
         if (sig(sel) == 1) cnt++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.motor_en     = 1'b0;
      bus.spin_mode    = 1'b1;
      bus.target_speed = 10'd0;
      bus.speed_fb     = 10'd0;
      bus.vibration    = 1'b0;
      reset_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      push_exp("rst_pwm", 0, 0);      check_obs(sig(SEL_PWM));
      push_exp("rst_dir", 1, 1);      check_obs(sig(SEL_DIR));
      push_exp("rst_brake", 0, 0);    check_obs(sig(SEL_BRAKE));
      push_exp("rst_at_speed", 0, 0); check_obs(sig(SEL_AT));
      push_exp("rst_fault", 0, 0);    check_obs(sig(SEL_FAULT));
      @(negedge clk) reset_n = 1'b1;

      // Soft start in spin mode
      @(negedge clk);
      bus.spin_mode    = 1'b1;
      bus.target_speed = 10'd40;
      bus.speed_fb     = 10'd40;
      bus.motor_en     = 1'b1;
      push_exp("t1_ramp_latency", 38, 43);
      wait_for(SEL_AT, 1, 100, n);
      check_obs(n);
      push_exp("t1_pwm_duty10", 10, 10);
      count_high(SEL_PWM, 256, n);
      check_obs(n);
      bad = 0;
      repeat (300) begin
         step();
         if (sig(SEL_AT) != 1 || sig(SEL_DIR) != 1 || sig(SEL_BRAKE) != 0) bad++;
      end
      push_exp("t1_spin_steady", 0, 0);
      check_obs(bad);

      // Stop and resume mid-deceleration
      @(negedge clk) bus.motor_en = 1'b0;
      push_exp("t3_at_speed_drop", 2, 2);
      wait_for(SEL_AT, 0, 10, n);
      check_obs(n);
      bad = 0;
      repeat (18) begin
         step();
         if (sig(SEL_BRAKE) != 0 || sig(SEL_FAULT) != 0) bad++;
      end
      push_exp("t3_decel_clean", 0, 0);
      check_obs(bad);
      @(negedge clk) bus.motor_en = 1'b1;
      push_exp("t3_resume_latency", 12, 26);
      wait_for(SEL_AT, 1, 60, n);
      check_obs(n);
      push_exp("t3_pwm_duty10", 10, 10);
      count_high(SEL_PWM, 256, n);
      check_obs(n);

      // Stall at duty with low tach feedback
      @(negedge clk) bus.speed_fb = 10'd5;
      push_exp("t4_stall_latency", 16, 16);
      wait_for(SEL_FAULT, 1, 40, n);
      check_obs(n);
      push_exp("t4_brake", 1, 1);
      check_obs(sig(SEL_BRAKE));
      step();
      push_exp("t4_pwm_low", 0, 0);
      count_high(SEL_PWM, 256, n);
      check_obs(n);
      push_exp("t4_fault_held", 1, 1);
      check_obs(sig(SEL_FAULT));
      @(negedge clk);
      bus.motor_en = 1'b0;
      bus.speed_fb = 10'd40;
      step();
      push_exp("t4_fault_clear", 0, 0); check_obs(sig(SEL_FAULT));
      push_exp("t4_brake_clear", 0, 0); check_obs(sig(SEL_BRAKE));

      @(negedge clk) reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;

      // Agitation reversal through a braked dwell
      @(negedge clk);
      bus.spin_mode = 1'b0;
      bus.motor_en  = 1'b1;
      push_exp("t2_brake_onset", 100, 110);
      wait_for(SEL_BRAKE, 1, 200, n);
      check_obs(n);
      push_exp("t2_dir_before", 1, 1);
      check_obs(sig(SEL_DIR));
      push_exp("t2_dwell_len", 8, 8);
      wait_for(SEL_BRAKE, 0, 20, n);
      check_obs(n);
      push_exp("t2_dir_toggled", 0, 0);
      check_obs(sig(SEL_DIR));
      push_exp("t2_reramp_latency", 37, 42);
      wait_for(SEL_AT, 1, 100, n);
      check_obs(n);

      // Async reset while driving CCW with PWM high
      @(negedge clk) bus.spin_mode = 1'b1;
      push_exp("t6_pwm_seen", 1, 300);
      wait_for(SEL_PWM, 1, 300, n);
      check_obs(n);
      push_exp("t6_at_speed_before", 1, 1);
      check_obs(sig(SEL_AT));
      #2 reset_n = 1'b0;
      #1;
      push_exp("t6_pwm", 0, 0);      check_obs(sig(SEL_PWM));
      push_exp("t6_dir", 1, 1);      check_obs(sig(SEL_DIR));
      push_exp("t6_brake", 0, 0);    check_obs(sig(SEL_BRAKE));
      push_exp("t6_at_speed", 0, 0); check_obs(sig(SEL_AT));
      push_exp("t6_fault", 0, 0);    check_obs(sig(SEL_FAULT));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Vibration in the same clock as reversal expiry
      bus.spin_mode = 1'b0;
      bus.motor_en  = 1'b1;
      repeat (64) step();
      push_exp("t5_fault_before", 0, 0);
      check_obs(sig(SEL_FAULT));
      @(negedge clk) bus.vibration = 1'b1;
      step();
      push_exp("t5_fault_on_expiry", 1, 1); check_obs(sig(SEL_FAULT));
      push_exp("t5_brake", 1, 1);           check_obs(sig(SEL_BRAKE));
      step();
      push_exp("t5_pwm_low", 0, 0);         check_obs(sig(SEL_PWM));
      @(negedge clk) bus.vibration = 1'b0;
      repeat (5) step();
      push_exp("t5_hold_motor_en", 1, 1);   check_obs(sig(SEL_FAULT));
      @(negedge clk);
      bus.vibration = 1'b1;
      bus.motor_en  = 1'b0;
      step();
      push_exp("t5_hold_vibration", 1, 1);  check_obs(sig(SEL_FAULT));
      @(negedge clk) bus.vibration = 1'b0;
      step();
      push_exp("t5_exit_fault", 0, 0);      check_obs(sig(SEL_FAULT));
      push_exp("t5_exit_brake", 0, 0);      check_obs(sig(SEL_BRAKE));

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
